// File: rtl/ppu_pkg.sv
// -----------------------------------------------------------------------------
// ppu_pkg
// Shared definitions for the background fetch path of the PPU: fetch FSM
// state encoding, tile geometry, ROM address widths, default raster window
// constants, the fetch-target record and the attribute quadrant selector.
// No ports (package).
// -----------------------------------------------------------------------------
package ppu_pkg;

    // One 8-pixel NES tile spans 16 VGA columns (and 16 VGA rows).
    localparam int C_TILE_PX = 16;

    // ROM address widths.
    localparam int C_NT_AW = 10;
    localparam int C_AT_AW = 7;
    localparam int C_PT_AW = 11;

    // Default raster geometry.
    localparam int C_H_TOTAL_DEF = 800;
    localparam int C_V_TOTAL_DEF = 525;
    localparam int C_H_ACT_DEF   = 512;
    localparam int C_V_ACT_DEF   = 480;

    // Fetch FSM encoding. One step per pixel strobe.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_NT_RD  = 3'd1;
    localparam logic [2:0] S_NT_CAP = 3'd2;
    localparam logic [2:0] S_AT_RD  = 3'd3;
    localparam logic [2:0] S_AT_CAP = 3'd4;
    localparam logic [2:0] S_PT_RD  = 3'd5;
    localparam logic [2:0] S_PT_CAP = 3'd6;
    localparam logic [2:0] S_WAIT   = 3'd7;

    // Tile being fetched: row/column in the 32x30 tile map plus the pixel
    // row inside the tile (NES rows, i.e. VGA row / 2).
    typedef struct packed {
        logic [4:0] row;
        logic [4:0] tcol;
        logic [2:0] fine_y;
    } fetch_tgt_t;

    // An attribute byte covers a 4x4-tile block; each 2x2-tile quadrant has
    // its own 2-bit palette select. row_b1/col_b1 pick the quadrant.
    function automatic logic [1:0] attr_quadrant(input logic [7:0] at_byte,
                                                 input logic       row_b1,
                                                 input logic       col_b1);
        logic [7:0] shifted;
        shifted = at_byte >> {row_b1, col_b1, 1'b0};
        return shifted[1:0];
    endfunction

endpackage

// File: rtl/ppu_bg_shifter.sv
// -----------------------------------------------------------------------------
// ppu_bg_shifter
// Holds the tile currently being displayed: two 8-bit pattern bit-plane
// shift registers and the 2-bit attribute latch. The MSB of each plane is
// the current NES pixel.
//   clk, rst    : clock, asynchronous active-low reset
//   load_i      : parallel load of planes and attribute (wins over shift)
//   shift_i     : advance to the next NES pixel (shift left by one)
//   plane0_i/1_i: next tile's pattern bit-planes
//   attr_i      : next tile's palette select
//   idx_o       : palette index of the current pixel, 0 when transparent
// -----------------------------------------------------------------------------
module ppu_bg_shifter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       shift_i,
    input  logic [7:0] plane0_i,
    input  logic [7:0] plane1_i,
    input  logic [1:0] attr_i,
    output logic [3:0] idx_o
);

    logic [7:0] plane0_q;
    logic [7:0] plane1_q;
    logic [1:0] attr_q;

    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; every flop here is a plain register, so all of them
    // are cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            plane0_q <= '0;
            plane1_q <= '0;
            attr_q   <= '0;
        end else if (load_i) begin
            plane0_q <= plane0_i;
            plane1_q <= plane1_i;
            attr_q   <= attr_i;
        end else if (shift_i) begin
            plane0_q <= {plane0_q[6:0], 1'b0};
            plane1_q <= {plane1_q[6:0], 1'b0};
        end
    end

    // Colour 0 of every background palette is the shared backdrop entry.
    assign idx_o = (plane1_q[7] | plane0_q[7]) ?
                   {attr_q, plane1_q[7], plane0_q[7]} : 4'h0;

endmodule

// File: rtl/ppu_bg_fetch.sv
// -----------------------------------------------------------------------------
// ppu_bg_fetch
// Background tile fetcher and pixel serializer. Fetches one tile ahead of
// the raster (nametable, attribute, two pattern planes) and serializes it
// as 4-bit palette indices, each NES pixel covering 2x2 VGA pixels.
//   clk, rst         : clock, asynchronous active-low reset
//   pxl_en           : pixel strobe; all state advances only on this cycle
//   visible          : raster is in the active display area
//   col, fila        : current VGA column / row
//   addr_ntable      : {tile_row, tile_col}            -> d_ntable (1 clk)
//   addr_atable      : {0, tile_row[4:2], tile_col[4:2]} -> d_atable (1 clk)
//   addr_ptable_bg   : {tile_idx, fine_y}               -> d_ptable_bg_0/1
//   pal_idx, pal_vld : registered palette index and window-valid flag
// -----------------------------------------------------------------------------
module ppu_bg_fetch
    import ppu_pkg::*;
#(
    parameter int C_MEMW    = 8,
    parameter int C_H_TOTAL = C_H_TOTAL_DEF,
    parameter int C_V_TOTAL = C_V_TOTAL_DEF,
    parameter int C_H_ACT   = C_H_ACT_DEF,
    parameter int C_V_ACT   = C_V_ACT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pxl_en,
    input  logic               visible,
    input  logic [9:0]         col,
    input  logic [9:0]         fila,
    output logic [C_NT_AW-1:0] addr_ntable,
    input  logic [C_MEMW-1:0]  d_ntable,
    output logic [C_AT_AW-1:0] addr_atable,
    input  logic [C_MEMW-1:0]  d_atable,
    output logic [C_PT_AW-1:0] addr_ptable_bg,
    input  logic [C_MEMW-1:0]  d_ptable_bg_0,
    input  logic [C_MEMW-1:0]  d_ptable_bg_1,
    output logic [3:0]         pal_idx,
    output logic               pal_vld
);

    localparam logic [9:0] H_LAST      = 10'(C_H_TOTAL - 1);
    localparam logic [9:0] H_PREFETCH  = 10'(C_H_TOTAL - C_TILE_PX);
    localparam logic [9:0] H_ACT       = 10'(C_H_ACT);
    localparam logic [9:0] H_FETCH_END = 10'(C_H_ACT - C_TILE_PX);
    localparam logic [9:0] V_LAST      = 10'(C_V_TOTAL - 1);
    localparam logic [9:0] V_ACT       = 10'(C_V_ACT);

    logic [2:0]         state_q,    state_d;
    fetch_tgt_t         tgt_q,      tgt_d;
    logic [7:0]         tile_idx_q, tile_idx_d;
    logic [1:0]         attr_q,     attr_d;
    logic [7:0]         plane0_q,   plane0_d;
    logic [7:0]         plane1_q,   plane1_d;
    logic [C_NT_AW-1:0] addr_nt_q,  addr_nt_d;
    logic [C_AT_AW-1:0] addr_at_q,  addr_at_d;
    logic [C_PT_AW-1:0] addr_pt_q,  addr_pt_d;
    logic               pre_done_q, pre_done_d;
    logic               primed_q,   primed_d;
    logic [3:0]         pal_idx_q,  pal_idx_d;
    logic               pal_vld_q,  pal_vld_d;

    logic [9:0] next_line;
    logic [9:0] line_sel;
    logic       start_win;
    logic       start_pre;
    fetch_tgt_t new_tgt;
    logic       in_window;
    logic       sh_load;
    logic       sh_shift;
    logic [3:0] sh_idx;
    logic       unused_line_bits;

    // ------------------------------------------------------------------
    // Fetch target selection
    // ------------------------------------------------------------------
    assign next_line = (fila == V_LAST) ? 10'd0 : fila + 10'd1;

    // In-window fetches start on every tile boundary except the last tile
    // (nothing left to fetch); the tile-0 prefetch runs one tile before the
    // end of the line and targets the following line.
    assign start_win = (col < H_FETCH_END) && (col[3:0] == 4'd0) && (fila < V_ACT);
    assign start_pre = (col == H_PREFETCH) && (next_line < V_ACT);

    assign line_sel       = start_pre ? next_line : fila;
    assign new_tgt.row    = line_sel[8:4];
    assign new_tgt.fine_y = line_sel[3:1];
    assign new_tgt.tcol   = start_pre ? 5'd0 : col[8:4] + 5'd1;

    assign unused_line_bits = ^{line_sel[9], line_sel[0]};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        tgt_d      = tgt_q;
        tile_idx_d = tile_idx_q;
        attr_d     = attr_q;
        plane0_d   = plane0_q;
        plane1_d   = plane1_q;
        addr_nt_d  = addr_nt_q;
        addr_at_d  = addr_at_q;
        addr_pt_d  = addr_pt_q;
        pre_done_d = pre_done_q;
        primed_d   = primed_q;
        pal_idx_d  = pal_idx_q;
        pal_vld_d  = pal_vld_q;

        if (pxl_en) begin
            // Each address is registered on entry to its *_RD state, so it is
            // stable for the whole state and the ROM output is ready by the
            // following *_CAP strobe.
            case (state_q)
                S_IDLE: begin
                    if (start_win || start_pre) begin
                        state_d   = S_NT_RD;
                        tgt_d     = new_tgt;
                        addr_nt_d = {new_tgt.row, new_tgt.tcol};
                    end
                end
                S_NT_RD:  state_d = S_NT_CAP;
                S_NT_CAP: begin
                    tile_idx_d = d_ntable[7:0];
                    addr_at_d  = {1'b0, tgt_q.row[4:2], tgt_q.tcol[4:2]};
                    state_d    = S_AT_RD;
                end
                S_AT_RD:  state_d = S_AT_CAP;
                S_AT_CAP: begin
                    attr_d    = attr_quadrant(d_atable[7:0], tgt_q.row[1], tgt_q.tcol[1]);
                    addr_pt_d = {tile_idx_q, tgt_q.fine_y};
                    state_d   = S_PT_RD;
                end
                S_PT_RD:  state_d = S_PT_CAP;
                S_PT_CAP: begin
                    plane0_d = d_ptable_bg_0[7:0];
                    plane1_d = d_ptable_bg_1[7:0];
                    // Only the prefetch targets tile column 0.
                    if (tgt_q.tcol == 5'd0) begin
                        pre_done_d = 1'b1;
                    end
                    state_d = S_WAIT;
                end
                default:  state_d = S_IDLE;
            endcase

            // Output stays invalid after reset until a complete tile-0
            // prefetch has been loaded, so the first shown line is whole.
            if (col == H_LAST) begin
                pre_done_d = 1'b0;
                if (pre_done_q) begin
                    primed_d = 1'b1;
                end
            end

            pal_vld_d = primed_q && in_window;
            pal_idx_d = (primed_q && in_window) ? sh_idx : 4'h0;
        end
    end

    assign in_window = visible && (col < H_ACT) && (fila < V_ACT);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            tgt_q      <= '0;
            tile_idx_q <= '0;
            attr_q     <= '0;
            plane0_q   <= '0;
            plane1_q   <= '0;
            addr_nt_q  <= '0;
            addr_at_q  <= '0;
            addr_pt_q  <= '0;
            pre_done_q <= 1'b0;
            primed_q   <= 1'b0;
            pal_idx_q  <= '0;
            pal_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            tile_idx_q <= tile_idx_d;
            attr_q     <= attr_d;
            plane0_q   <= plane0_d;
            plane1_q   <= plane1_d;
            addr_nt_q  <= addr_nt_d;
            addr_at_q  <= addr_at_d;
            addr_pt_q  <= addr_pt_d;
            pre_done_q <= pre_done_d;
            primed_q   <= primed_d;
            pal_idx_q  <= pal_idx_d;
            pal_vld_q  <= pal_vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Serializer: load on the last column of each tile (or the end of the
    // line for tile 0), shift on odd columns so each NES pixel lasts 2 cols.
    // ------------------------------------------------------------------
    assign sh_load  = pxl_en && (((col < H_ACT) && (col[3:0] == 4'hF)) || (col == H_LAST));
    assign sh_shift = pxl_en && col[0] && (col < H_ACT);

    ppu_bg_shifter u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load_i   (sh_load),
        .shift_i  (sh_shift),
        .plane0_i (plane0_q),
        .plane1_i (plane1_q),
        .attr_i   (attr_q),
        .idx_o    (sh_idx)
    );

    assign addr_ntable    = addr_nt_q;
    assign addr_atable    = addr_at_q;
    assign addr_ptable_bg = addr_pt_q;
    assign pal_idx        = pal_idx_q;
    assign pal_vld        = pal_vld_q;

endmodule

// File: tb/tb_ppu_bg_fetch.sv
// -----------------------------------------------------------------------------
// tb_ppu_bg_fetch
// Drives raster positions with pixel strobes, models the four synchronous
// ROMs, and compares every registered output against a reference model of
// the background pixel at that position (scoreboard queue), plus targeted
// address, window-edge, attribute and stall checks.
// -----------------------------------------------------------------------------
module tb_ppu_bg_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        pxl_en;
    logic        visible;
    logic [9:0]  col;
    logic [9:0]  fila;
    logic [9:0]  addr_ntable;
    logic [7:0]  d_ntable;
    logic [6:0]  addr_atable;
    logic [7:0]  d_atable;
    logic [10:0] addr_ptable_bg;
    logic [7:0]  d_ptable_bg_0;
    logic [7:0]  d_ptable_bg_1;
    logic [3:0]  pal_idx;
    logic        pal_vld;

    always #5 clk = ~clk;

    ppu_bg_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .pxl_en         (pxl_en),
        .visible        (visible),
        .col            (col),
        .fila           (fila),
        .addr_ntable    (addr_ntable),
        .d_ntable       (d_ntable),
        .addr_atable    (addr_atable),
        .d_atable       (d_atable),
        .addr_ptable_bg (addr_ptable_bg),
        .d_ptable_bg_0  (d_ptable_bg_0),
        .d_ptable_bg_1  (d_ptable_bg_1),
        .pal_idx        (pal_idx),
        .pal_vld        (pal_vld)
    );

    // Synchronous ROMs, 1-clk read latency.
    logic [7:0] nt_mem  [1024];
    logic [7:0] at_mem  [128];
    logic [7:0] pt0_mem [2048];
    logic [7:0] pt1_mem [2048];

    always @(posedge clk) begin
        d_ntable      <= nt_mem[addr_ntable];
        d_atable      <= at_mem[addr_atable];
        d_ptable_bg_0 <= pt0_mem[addr_ptable_bg];
        d_ptable_bg_1 <= pt1_mem[addr_ptable_bg];
    end

    int         n_checks = 0;
    int         n_errors = 0;
    int         gap = 2;
    bit         model_primed = 1'b0;
    bit         check_hold = 1'b0;
    logic [4:0] sb_q [$];
    logic [3:0] obs_idx [800];
    logic       obs_vld [800];
    logic [3:0] ref_idx [48];

    // Expected {pal_vld, pal_idx} for a pixel, computed from the ROM contents.
    function automatic logic [4:0] model_pix(input int c, input int f, input bit v);
        int         row, tile, fy, x, sh, pa;
        logic [7:0] idx, atb;
        logic [1:0] a;
        logic       p0, p1;
        if (!(model_primed && v && c < 512 && f < 480)) return 5'b0;
        row  = f / 16;
        tile = c / 16;
        fy   = (f / 2) % 8;
        x    = (c % 16) / 2;
        idx  = nt_mem[row * 32 + tile];
        atb  = at_mem[(row / 4) * 8 + tile / 4];
        sh   = ((row / 2) % 2) * 4 + ((tile / 2) % 2) * 2;
        a    = 2'((atb >> sh) & 8'h03);
        pa   = int'(idx) * 8 + fy;
        p0   = pt0_mem[pa][7 - x];
        p1   = pt1_mem[pa][7 - x];
        if (!p0 && !p1) return {1'b1, 4'h0};
        return {1'b1, a, p1, p0};
    endfunction

    // One pixel strobe with an explicit expected result.
    task automatic pix_exp(input int c, input int f, input bit v, input logic [4:0] exp_val);
        logic [4:0]  got;
        logic [32:0] snap;
        @(negedge clk);
        col     = 10'(c);
        fila    = 10'(f);
        visible = v;
        pxl_en  = 1'b1;
        sb_q.push_back(exp_val);
        @(posedge clk);
        #1;
        pxl_en = 1'b0;
        got = sb_q.pop_front();
        n_checks++;
        if ({pal_vld, pal_idx} !== got) begin
            n_errors++;
            $display("FAIL pixel col=%0d fila=%0d vis=%0b: got vld=%b idx=%h, expected vld=%b idx=%h",
                     c, f, v, pal_vld, pal_idx, got[4], got[3:0]);
        end
        obs_idx[c] = pal_idx;
        obs_vld[c] = pal_vld;
        if (gap > 1) begin
            snap = {pal_vld, pal_idx, addr_ntable, addr_atable, addr_ptable_bg};
            repeat (gap - 1) @(posedge clk);
            #1;
            if (check_hold) begin
                n_checks++;
                if ({pal_vld, pal_idx, addr_ntable, addr_atable, addr_ptable_bg} !== snap) begin
                    n_errors++;
                    $display("FAIL hold col=%0d: outputs %h changed while pxl_en=0, expected %h",
                             c, {pal_vld, pal_idx, addr_ntable, addr_atable, addr_ptable_bg}, snap);
                end
            end
        end
    endtask

    task automatic pix(input int c, input int f, input bit v);
        pix_exp(c, f, v, model_pix(c, f, v));
    endtask

    // Tile-0 prefetch for line L: last tile of the previous line, blanked.
    task automatic prefetch(input int line);
        int prev;
        prev = (line == 0) ? 524 : line - 1;
        for (int c = 784; c < 800; c++) pix(c, prev, 1'b0);
        if (line < 480) model_primed = 1'b1;
    endtask

    task automatic line_run(input int line, input int ncols, input bit v);
        prefetch(line);
        for (int c = 0; c < ncols; c++) pix(c, line, v);
    endtask

    task automatic check_zero_outputs(input string name);
        n_checks++;
        if ({addr_ntable, addr_atable, addr_ptable_bg, pal_idx, pal_vld} !== '0) begin
            n_errors++;
            $display("FAIL %s: nt=%h at=%h pt=%h idx=%h vld=%b, expected all 0",
                     name, addr_ntable, addr_atable, addr_ptable_bg, pal_idx, pal_vld);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pxl_en  = 1'($urandom);
            visible = 1'($urandom);
            col     = 10'($urandom_range(0, 799));
            fila    = 10'($urandom_range(0, 524));
            @(posedge clk);
            #1;
            check_zero_outputs("reset_hold");
        end
        @(negedge clk);
        pxl_en = 1'b0;
        rst    = 1'b1;
        model_primed = 1'b0;
        // Released mid-line: nothing valid until the next tile-0 prefetch.
        for (int c = 100; c < 144; c++) pix(c, 3, 1'b1);
    endtask

    task automatic test_single_tile();
        logic [3:0] e;
        prefetch(0);
        for (int c = 0; c < 16; c++) begin
            e = (c < 2 || c >= 14) ? 4'h3 : 4'h2;
            pix_exp(c, 0, 1'b1, {1'b1, e});
        end
        for (int c = 16; c < 32; c++) pix(c, 0, 1'b1);
    endtask

    task automatic test_attr();
        line_run(0, 48, 1'b1);
        n_checks++;
        if ({obs_vld[32], obs_idx[32][3:2]} !== 3'b1_01) begin
            n_errors++;
            $display("FAIL attr_r0c2: got vld=%b attr=%0d, expected vld=1 attr=1", obs_vld[32], obs_idx[32][3:2]);
        end
        line_run(32, 48, 1'b1);
        n_checks++;
        if ({obs_vld[0], obs_idx[0][3:2]} !== 3'b1_10) begin
            n_errors++;
            $display("FAIL attr_r2c0: got vld=%b attr=%0d, expected vld=1 attr=2", obs_vld[0], obs_idx[0][3:2]);
        end
        n_checks++;
        if ({obs_vld[32], obs_idx[32][3:2]} !== 3'b1_11) begin
            n_errors++;
            $display("FAIL attr_r2c2: got vld=%b attr=%0d, expected vld=1 attr=3", obs_vld[32], obs_idx[32][3:2]);
        end
    endtask

    task automatic test_window();
        logic [27:0] snap;
        line_run(5, 496, 1'b1);
        snap = {addr_ntable, addr_atable, addr_ptable_bg};
        for (int c = 496; c < 512; c++) begin
            pix(c, 5, 1'b1);
            n_checks++;
            if ({addr_ntable, addr_atable, addr_ptable_bg} !== snap) begin
                n_errors++;
                $display("FAIL no_fetch col=%0d: addrs %h, expected unchanged %h",
                         c, {addr_ntable, addr_atable, addr_ptable_bg}, snap);
            end
        end
        n_checks++;
        if (obs_vld[511] !== 1'b1) begin
            n_errors++;
            $display("FAIL col511_vld: got %b, expected 1", obs_vld[511]);
        end
        pix(512, 5, 1'b1);
        n_checks++;
        if ({pal_vld, pal_idx} !== 5'b0) begin
            n_errors++;
            $display("FAIL col512: got vld=%b idx=%h, expected vld=0 idx=0", pal_vld, pal_idx);
        end
        pix(10, 480, 1'b1);
        pix(10, 5, 1'b0);
    endtask

    task automatic test_frame_wrap();
        for (int c = 0; c < 16; c++) begin
            pix(c, 100, 1'b0);
            if (c == 0) begin
                n_checks++;
                if (addr_ntable !== 10'h0C1) begin
                    n_errors++;
                    $display("FAIL nt_line100: got %h, expected 0c1", addr_ntable);
                end
            end
        end
        for (int c = 784; c < 800; c++) begin
            pix(c, 524, 1'b0);
            if (c == 784) begin
                n_checks++;
                if (addr_ntable !== 10'h000) begin
                    n_errors++;
                    $display("FAIL nt_wrap: got %h, expected 000", addr_ntable);
                end
            end
        end
        n_checks++;
        if (addr_ptable_bg !== {nt_mem[0], 3'd0}) begin
            n_errors++;
            $display("FAIL pt_wrap: got %h, expected %h", addr_ptable_bg, {nt_mem[0], 3'd0});
        end
        for (int c = 784; c < 800; c++) pix(c, 15, 1'b0);
        n_checks++;
        if ({addr_ntable, addr_ptable_bg[2:0]} !== {10'h020, 3'd0}) begin
            n_errors++;
            $display("FAIL nt_row1: got nt=%h fy=%0d, expected nt=020 fy=0", addr_ntable, addr_ptable_bg[2:0]);
        end
        for (int c = 784; c < 800; c++) pix(c, 35, 1'b0);
        n_checks++;
        if ({addr_ntable, addr_ptable_bg[2:0]} !== {10'h040, 3'd2}) begin
            n_errors++;
            $display("FAIL nt_row2: got nt=%h fy=%0d, expected nt=040 fy=2", addr_ntable, addr_ptable_bg[2:0]);
        end
    endtask

    task automatic test_stall();
        int diffs;
        check_hold = 1'b1;
        gap = 2;
        line_run(40, 48, 1'b1);
        for (int c = 0; c < 48; c++) ref_idx[c] = obs_idx[c];
        for (int g = 3; g >= 1; g -= 2) begin
            gap = g;
            line_run(40, 48, 1'b1);
            diffs = 0;
            for (int c = 0; c < 48; c++) if (obs_idx[c] !== ref_idx[c]) diffs++;
            n_checks++;
            if (diffs != 0) begin
                n_errors++;
                $display("FAIL stall_gap%0d: %0d pixels differ from gap-2 run, expected 0", g, diffs);
            end
        end
        check_hold = 1'b0;
        gap = 2;
    endtask

    task automatic test_reset_mid_fetch();
        prefetch(6);
        for (int c = 0; c < 3; c++) pix(c, 6, 1'b1);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        model_primed = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 100; c < 144; c++) pix(c, 3, 1'b1);
        line_run(4, 32, 1'b1);
    endtask

    // ------------------------------------------------------------------
    initial begin
        rst     = 1'b0;
        pxl_en  = 1'b0;
        visible = 1'b0;
        col     = '0;
        fila    = '0;
        for (int i = 0; i < 1024; i++) nt_mem[i] = 8'($urandom);
        for (int i = 0; i < 128; i++)  at_mem[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) begin
            pt0_mem[i] = 8'($urandom);
            pt1_mem[i] = 8'($urandom);
        end
        nt_mem[0]      = 8'h24;
        nt_mem[2]      = 8'h24;
        nt_mem[64]     = 8'h24;
        nt_mem[66]     = 8'h24;
        at_mem[0]      = 8'hE4;
        pt0_mem[11'h120] = 8'h81;
        pt1_mem[11'h120] = 8'hFF;

        test_reset();
        test_single_tile();
        test_attr();
        test_window();
        test_frame_wrap();
        test_stall();
        test_reset_mid_fetch();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
